// File: rtl/module_fifo_recir.sv
// ----------------------------------------------------------------------------
// module_fifo_recir
//
// Synchronous FIFO sitting directly behind the recirculation stage. It stores
// the words forwarded on the normal (non-return) path and hands them to the
// next stage on request. The almost-full flag goes back upstream as a pause
// request, so traffic can be diverted to the return path before words are
// lost.
//
// Ports:
//   clk_Fifo           in   single clock, all state changes on rising edge
//   reset_L            in   synchronous active-low reset
//   valid_in_Fifo      in   push request, qualifies data_in_Fifo
//   data_in_Fifo       in   word to store
//   pop_Fifo           in   read request from downstream
//   data_out_Fifo      out  registered read data
//   valid_out_Fifo     out  data_out_Fifo holds a word popped on the last edge
//   empty_Fifo         out  count == 0
//   full_Fifo          out  count == depth
//   almost_full_Fifo   out  count >= ALMOST_FULL (upstream pause)
//   almost_empty_Fifo  out  count <= ALMOST_EMPTY
//   error_Fifo         out  sticky overflow indicator, cleared only by reset
//   count_Fifo         out  current occupancy (0..depth)
// ----------------------------------------------------------------------------
module module_fifo_recir #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk_Fifo,
    input  logic                  reset_L,
    input  logic                  valid_in_Fifo,
    input  logic [DATA_WIDTH-1:0] data_in_Fifo,
    input  logic                  pop_Fifo,
    output logic [DATA_WIDTH-1:0] data_out_Fifo,
    output logic                  valid_out_Fifo,
    output logic                  empty_Fifo,
    output logic                  full_Fifo,
    output logic                  almost_full_Fifo,
    output logic                  almost_empty_Fifo,
    output logic                  error_Fifo,
    output logic [ADDR_WIDTH:0]   count_Fifo
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0]   CNT_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic                  vout_q,   vout_d;
    logic                  err_q,    err_d;

    logic push_ok;
    logic pop_ok;

    // Flags decode only the registered count, so no input reaches an output
    // combinationally.
    assign empty_Fifo        = (count_q == '0);
    assign full_Fifo         = (count_q == CNT_DEPTH);
    assign almost_full_Fifo  = (count_q >= CNT_AF);
    assign almost_empty_Fifo = (count_q <= CNT_AE);

    // A push while full is dropped even if a pop frees a slot on the same
    // edge; a pop while empty is ignored even if a push arrives with it.
    assign push_ok = valid_in_Fifo & ~full_Fifo;
    assign pop_ok  = pop_Fifo & ~empty_Fifo;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        vout_d   = 1'b0;
        err_d    = err_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (valid_in_Fifo && full_Fifo) begin
            err_d = 1'b1;
        end
        if (pop_ok) begin
            dout_d   = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            vout_d   = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_Fifo) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
            err_q    <= err_d;
        end
    end

    // Storage array is not cleared on reset; the pointers make stale words
    // unreachable.
    always_ff @(posedge clk_Fifo) begin
        if (reset_L && push_ok) begin
            mem[wr_ptr_q] <= data_in_Fifo;
        end
    end

    assign data_out_Fifo  = dout_q;
    assign valid_out_Fifo = vout_q;
    assign error_Fifo     = err_q;
    assign count_Fifo     = count_q;

endmodule

// File: tb/tb_module_fifo_recir.sv
// ----------------------------------------------------------------------------
// Testbench for module_fifo_recir. A queue-based reference model tracks the
// stored words, the sticky error and the last popped word.
// ----------------------------------------------------------------------------
module tb_module_fifo_recir;

    logic        clk_Fifo = 1'b0;
    logic        reset_L;
    logic        valid_in_Fifo;
    logic [31:0] data_in_Fifo;
    logic        pop_Fifo;
    logic [31:0] data_out_Fifo;
    logic        valid_out_Fifo;
    logic        empty_Fifo;
    logic        full_Fifo;
    logic        almost_full_Fifo;
    logic        almost_empty_Fifo;
    logic        error_Fifo;
    logic [3:0]  count_Fifo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_err  = 1'b0;
    logic [31:0] m_dout = '0;
    logic        m_vout = 1'b0;

    module_fifo_recir #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (3),
        .ALMOST_FULL (6),
        .ALMOST_EMPTY(1)
    ) dut (
        .clk_Fifo         (clk_Fifo),
        .reset_L          (reset_L),
        .valid_in_Fifo    (valid_in_Fifo),
        .data_in_Fifo     (data_in_Fifo),
        .pop_Fifo         (pop_Fifo),
        .data_out_Fifo    (data_out_Fifo),
        .valid_out_Fifo   (valid_out_Fifo),
        .empty_Fifo       (empty_Fifo),
        .full_Fifo        (full_Fifo),
        .almost_full_Fifo (almost_full_Fifo),
        .almost_empty_Fifo(almost_empty_Fifo),
        .error_Fifo       (error_Fifo),
        .count_Fifo       (count_Fifo)
    );

    always #5 clk_Fifo = ~clk_Fifo;

    // Drive one cycle of inputs, advance the model at the edge, then settle.
    task automatic step(input logic rst_n, input logic v, input logic [31:0] d, input logic p);
        bit was_full, was_empty;
        reset_L       = rst_n;
        valid_in_Fifo = v;
        data_in_Fifo  = d;
        pop_Fifo      = p;
        @(posedge clk_Fifo);
        if (!rst_n) begin
            m_q.delete();
            m_err  = 1'b0;
            m_dout = '0;
            m_vout = 1'b0;
        end else begin
            was_full  = (m_q.size() == 8);
            was_empty = (m_q.size() == 0);
            if (v && was_full) m_err = 1'b1;
            if (p && !was_empty) begin
                m_dout = m_q.pop_front();
                m_vout = 1'b1;
            end else begin
                m_vout = 1'b0;
            end
            if (v && !was_full) m_q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        n_checks++; if (count_Fifo !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_Fifo); end
        n_checks++; if (empty_Fifo !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_Fifo); end
        n_checks++; if (almost_empty_Fifo !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b exp 1", almost_empty_Fifo); end
        n_checks++; if (full_Fifo !== 1'b0 || almost_full_Fifo !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b/%b exp 0/0", full_Fifo, almost_full_Fifo); end
        n_checks++; if (valid_out_Fifo !== 1'b0) begin n_fail++; $display("FAIL reset_vout got %b exp 0", valid_out_Fifo); end
        n_checks++; if (data_out_Fifo !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", data_out_Fifo); end
        n_checks++; if (error_Fifo !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", error_Fifo); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 32'(i), 1'b0);
            n_checks++; if (count_Fifo !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count_Fifo, i); end
            n_checks++; if (almost_full_Fifo !== (i >= 6)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full_Fifo, (i >= 6)); end
            n_checks++; if (full_Fifo !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, full_Fifo, (i == 8)); end
            n_checks++; if (almost_empty_Fifo !== (i <= 1)) begin n_fail++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, almost_empty_Fifo, (i <= 1)); end
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            n_checks++; if (valid_out_Fifo !== 1'b1) begin n_fail++; $display("FAIL drain_vout[%0d] got %b exp 1", i, valid_out_Fifo); end
            n_checks++; if (data_out_Fifo !== 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_out_Fifo, 32'(i)); end
            n_checks++; if (count_Fifo !== 4'(8 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count_Fifo, 8 - i); end
        end
        n_checks++; if (empty_Fifo !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty_Fifo); end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++; if (valid_out_Fifo !== 1'b0) begin n_fail++; $display("FAIL drain_idle_vout got %b exp 0", valid_out_Fifo); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
        n_checks++; if (error_Fifo !== 1'b1) begin n_fail++; $display("FAIL ovf_error got %b exp 1", error_Fifo); end
        n_checks++; if (count_Fifo !== 4'd7) begin n_fail++; $display("FAIL ovf_count got %0d exp 7", count_Fifo); end
        n_checks++; if (data_out_Fifo !== 32'h101 || valid_out_Fifo !== 1'b1) begin n_fail++; $display("FAIL ovf_pop got %h/%b exp 00000101/1", data_out_Fifo, valid_out_Fifo); end
        for (int i = 2; i <= 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            n_checks++; if (data_out_Fifo !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, data_out_Fifo, 32'h100 + 32'(i)); end
        end
        n_checks++; if (error_Fifo !== 1'b1 || empty_Fifo !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got err=%b empty=%b exp 1/1", error_Fifo, empty_Fifo); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (error_Fifo !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", error_Fifo); end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_checks++; if (valid_out_Fifo !== 1'b0 || error_Fifo !== 1'b0) begin n_fail++; $display("FAIL unf_pop got vout=%b err=%b exp 0/0", valid_out_Fifo, error_Fifo); end
        n_checks++; if (data_out_Fifo !== m_dout) begin n_fail++; $display("FAIL unf_hold got %h exp %h", data_out_Fifo, m_dout); end
        step(1'b1, 1'b1, 32'hA5A5A5A5, 1'b1);
        n_checks++; if (count_Fifo !== 4'd1 || valid_out_Fifo !== 1'b0) begin n_fail++; $display("FAIL unf_pushpop got cnt=%0d vout=%b exp 1/0", count_Fifo, valid_out_Fifo); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_checks++; if (data_out_Fifo !== 32'hA5A5A5A5 || valid_out_Fifo !== 1'b1) begin n_fail++; $display("FAIL unf_next got %h/%b exp a5a5a5a5/1", data_out_Fifo, valid_out_Fifo); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 32'h5000 + 32'(i), 1'b1);
            n_checks++; if (count_Fifo !== 4'd3) begin n_fail++; $display("FAIL stream_count[%0d] got %0d exp 3", i, count_Fifo); end
            n_checks++; if (data_out_Fifo !== m_dout || valid_out_Fifo !== 1'b1) begin n_fail++; $display("FAIL stream_data[%0d] got %h/%b exp %h/1", i, data_out_Fifo, valid_out_Fifo, m_dout); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            n_checks++; if (data_out_Fifo !== 32'h5011 + 32'(i)) begin n_fail++; $display("FAIL stream_tail[%0d] got %h exp %h", i, data_out_Fifo, 32'h5011 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0);
        n_checks++; if (count_Fifo !== 4'd5) begin n_fail++; $display("FAIL rmid_pre got %0d exp 5", count_Fifo); end
        step(1'b0, 1'b1, 32'h12345678, 1'b1);
        n_checks++; if (count_Fifo !== 4'd0 || empty_Fifo !== 1'b1) begin n_fail++; $display("FAIL rmid_count got %0d/%b exp 0/1", count_Fifo, empty_Fifo); end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        n_checks++; if (valid_out_Fifo !== 1'b0) begin n_fail++; $display("FAIL rmid_pop got %b exp 0", valid_out_Fifo); end
    endtask

    task automatic test_random();
        int sz;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 99) < 55), $urandom,
                 ($urandom_range(0, 99) < 45));
            sz = m_q.size();
            n_checks++;
            if (count_Fifo !== 4'(sz) || empty_Fifo !== (sz == 0) || full_Fifo !== (sz == 8) ||
                almost_full_Fifo !== (sz >= 6) || almost_empty_Fifo !== (sz <= 1) ||
                error_Fifo !== m_err || valid_out_Fifo !== m_vout || data_out_Fifo !== m_dout) begin
                n_fail++;
                $display("FAIL random[%0d] got cnt=%0d e=%b f=%b af=%b ae=%b err=%b v=%b d=%h exp cnt=%0d err=%b v=%b d=%h",
                         i, count_Fifo, empty_Fifo, full_Fifo, almost_full_Fifo, almost_empty_Fifo,
                         error_Fifo, valid_out_Fifo, data_out_Fifo, sz, m_err, m_vout, m_dout);
            end
        end
    endtask

    initial begin
        reset_L       = 1'b0;
        valid_in_Fifo = 1'b0;
        data_in_Fifo  = '0;
        pop_Fifo      = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_stream();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_fifo_recir.md
# module_Fifo_Recir

Synchronous 32-bit FIFO placed directly downstream of the recirculation stage. It accepts the words the recirculation stage forwards on its normal (non-return) path, buffers them, and hands them to the next stage on a pop request. It reports occupancy flags; the almost-full flag is fed back upstream as a pause request so that traffic can be diverted to the return path before words are lost.

## Interface
Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 3, depth = 2**ADDR_WIDTH = 8 words.
- ALMOST_FULL, 6, almost_full asserted when count >= this value.
- ALMOST_EMPTY, 1, almost_empty asserted when count <= this value.

Ports:
- clk_Fifo  in  1  single clock; all state changes on rising edge.
- reset_L  in  1  synchronous, active-low reset, sampled on the rising edge of clk_Fifo.
- valid_in_Fifo  in  1  push request; qualifies data_in_Fifo.
- data_in_Fifo  in  DATA_WIDTH  word to store (from data_out_Recir).
- pop_Fifo  in  1  read request from downstream.
- data_out_Fifo  out  DATA_WIDTH  registered read data.
- valid_out_Fifo  out  1  data_out_Fifo holds a word popped on the previous edge.
- empty_Fifo  out  1  count == 0.
- full_Fifo  out  1  count == 2**ADDR_WIDTH.
- almost_full_Fifo  out  1  count >= ALMOST_FULL; upstream pause.
- almost_empty_Fifo  out  1  count <= ALMOST_EMPTY.
- error_Fifo  out  1  sticky overflow indicator.
- count_Fifo  out  ADDR_WIDTH+1  current occupancy.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array; write pointer wr_ptr, read pointer rd_ptr, each ADDR_WIDTH bits, wrap naturally from 7 to 0.
- count_Fifo is a registered ADDR_WIDTH+1-bit counter (0..8); all flags are combinational decodes of the count register only.
- Push accepted when valid_in_Fifo=1 and full_Fifo=0: word written at wr_ptr, wr_ptr+1.
- Push while full_Fifo=1: word dropped, pointers unchanged, error_Fifo set to 1 — also when pop_Fifo=1 in the same cycle (no write-through on full).
- Pop accepted when pop_Fifo=1 and empty_Fifo=0: data_out_Fifo <= mem[rd_ptr], rd_ptr+1, valid_out_Fifo <= 1.
- Pop while empty: ignored, valid_out_Fifo <= 0, data_out_Fifo holds last value, no error. Push and pop in the same cycle while empty: push accepted, pop ignored (no fall-through).
- Count update: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
- valid_out_Fifo is 0 in every cycle without an accepted pop.
- error_Fifo cleared only by reset.

## Timing
- Reset (reset_L=0 at an edge): wr_ptr=rd_ptr=0, count_Fifo=0, data_out_Fifo=0, valid_out_Fifo=0, error_Fifo=0; therefore empty_Fifo=1, almost_empty_Fifo=1, full_Fifo=0, almost_full_Fifo=0. Array contents need not be cleared. Reset takes priority over push/pop in the same cycle; a reset mid-stream discards all stored words.
- Write latency: word pushed at edge N can be popped at edge N+1; its data appears on data_out_Fifo after edge N+1 with valid_out_Fifo=1 (one-cycle read latency).
- Flags change in the cycle after the edge that changed count; no combinational path from valid_in_Fifo/pop_Fifo to any output.
- Upstream contract: almost_full_Fifo rises with 2 free slots, giving upstream 2 cycles of slack to divert to the return path.
- Back-to-back pops with count >= 1 yield one word per cycle in FIFO order.

## Test plan
- Reset: hold reset_L=0 two edges with valid_in_Fifo=1, data 0xDEADBEEF -> count 0, empty=1, valid_out=0, data_out=0, error=0.
- Fill and drain: push 0x00000001..0x00000008 on 8 consecutive edges -> almost_full after 6th, full after 8th; pop 8 times -> outputs 1..8 in order, valid_out high 8 cycles, empty after last, pointers wrapped.
- Overflow: with full, push 0xFFFFFFFF with pop_Fifo=1 -> word dropped, error=1, count 7, popped data is oldest word; error stays 1 until reset.
- Underflow / empty push+pop: pop on empty -> valid_out=0, no error; push 0xA5A5A5A5 with pop same cycle while empty -> count 1, valid_out=0; next pop returns 0xA5A5A5A5.
- Steady stream: count=3, push and pop every cycle for 20 cycles with incrementing data -> count stays 3, output sequence in order, wrap-around of both pointers crossing 7->0.
- Reset mid-operation: count=5, assert reset_L=0 one edge -> count 0, empty=1; next pop yields valid_out=0.
